// File: rtl/decode_stage_nwide_if.sv
// rtl/decode_stage_nwide_if.sv - fetch-in, issue-queue-out and redirect bus of the N-wide decode stage
interface decode_stage_nwide_if #(
    parameter int DECODE_WIDTH = 2,
    parameter int INSTR_BITS   = 32,
    parameter int PC_BITS      = 32,
    parameter int DEC_BITS     = PC_BITS + 21
);
    logic                               in_valid_i;
    logic                               in_ready_o;
    logic [DECODE_WIDTH-1:0]            in_lane_valid_i;
    logic [DECODE_WIDTH-1:0]            in_taken_i;
    logic [DECODE_WIDTH*PC_BITS-1:0]    in_pc_i;
    logic [DECODE_WIDTH*INSTR_BITS-1:0] in_instr_i;

    logic                               out_valid_o;
    logic                               out_ready_i;
    logic [DECODE_WIDTH-1:0]            out_lane_valid_o;
    logic [DECODE_WIDTH-1:0][DEC_BITS-1:0] out_instr_o;
    logic [DECODE_WIDTH-1:0]            out_branch_o;

    logic                               redirect_valid_o;
    logic [1:0]                         redirect_cause_o;
    logic [PC_BITS-1:0]                 redirect_pc_o;
    logic                               redirect_ack_i;

    modport master (
        output in_valid_i, in_lane_valid_i, in_taken_i, in_pc_i, in_instr_i,
        output out_ready_i, redirect_ack_i,
        input  in_ready_o, out_valid_o, out_lane_valid_o, out_instr_o, out_branch_o,
        input  redirect_valid_o, redirect_cause_o, redirect_pc_o
    );

    modport slave (
        input  in_valid_i, in_lane_valid_i, in_taken_i, in_pc_i, in_instr_i,
        input  out_ready_i, redirect_ack_i,
        output in_ready_o, out_valid_o, out_lane_valid_o, out_instr_o, out_branch_o,
        output redirect_valid_o, redirect_cause_o, redirect_pc_o
    );
endinterface

// File: rtl/decode_stage_nwide.sv
// rtl/decode_stage_nwide.sv - N-wide registered decode stage with redirect cut and wrong-path squash
// Decoded lane word: {pc, legal, branch, jumpl, return, mem, mem_port2, rd, rs1, rs2}.
module decoder_full #(
    parameter int INSTR_BITS = 32,
    parameter int PC_BITS    = 32
) (
    input  logic [INSTR_BITS-1:0] i_instr,
    input  logic [PC_BITS-1:0]    i_pc,
    input  logic                  i_second_port_free,
    output logic                  o_is_valid,
    output logic                  o_valid_branch,
    output logic                  o_is_jumpl,
    output logic                  o_is_return,
    output logic [PC_BITS+20:0]   o_dec
);
    logic [6:0] w_op;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic       w_is_op;
    logic       w_is_opimm;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_br;
    logic       w_is_jal;
    logic       w_is_jalr;
    logic       w_is_lui;
    logic       w_is_auipc;
    logic       w_legal;
    logic       w_mem;

    assign w_op  = i_instr[6:0];
    assign w_f3  = i_instr[14:12];
    assign w_f7  = i_instr[31:25];
    assign w_rd  = i_instr[11:7];
    assign w_rs1 = i_instr[19:15];
    assign w_rs2 = i_instr[24:20];

    assign w_is_op    = (w_op == 7'b0110011);
    assign w_is_opimm = (w_op == 7'b0010011);
    assign w_is_load  = (w_op == 7'b0000011);
    assign w_is_store = (w_op == 7'b0100011);
    assign w_is_br    = (w_op == 7'b1100011);
    assign w_is_jal   = (w_op == 7'b1101111);
    assign w_is_jalr  = (w_op == 7'b1100111);
    assign w_is_lui   = (w_op == 7'b0110111);
    assign w_is_auipc = (w_op == 7'b0010111);

    // funct3 = 010/011 are unassigned branch encodings
    assign w_legal = (w_is_op & ((w_f7 == 7'b0000000) | (w_f7 == 7'b0100000)))
                   | w_is_opimm | w_is_load | w_is_store
                   | (w_is_br & (w_f3[2:1] != 2'b01))
                   | w_is_jal | (w_is_jalr & (w_f3 == 3'b000))
                   | w_is_lui | w_is_auipc;

    assign w_mem          = w_legal & (w_is_load | w_is_store);
    assign o_is_valid     = w_legal;
    assign o_valid_branch = w_legal & (w_is_br | w_is_jal | w_is_jalr);
    assign o_is_jumpl     = w_legal & w_is_jalr;
    assign o_is_return    = w_legal & w_is_jalr & (w_rd == 5'd0) & (w_rs1 == 5'd1);

    assign o_dec = {i_pc, w_legal, o_valid_branch, o_is_jumpl, o_is_return,
                    w_mem, w_mem & i_second_port_free, w_rd, w_rs1, w_rs2};
endmodule

module decode_stage_nwide #(
    parameter int DECODE_WIDTH = 2,
    parameter int INSTR_BITS   = 32,
    parameter int PC_BITS      = 32,
    parameter int CNT_BITS     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  second_port_free_i,
    decode_stage_nwide_if.slave   bus,
    output logic [CNT_BITS-1:0]   stat_stall_cnt_o
);
    localparam int DEC_BITS = PC_BITS + 21;

    typedef enum logic {S_RUN, S_SQUASH} state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic                                  r_out_valid;
    logic [DECODE_WIDTH-1:0]               r_lane_valid;
    logic [DECODE_WIDTH-1:0]               r_branch;
    logic [DECODE_WIDTH-1:0][DEC_BITS-1:0] r_instr;
    logic                                  r_redir_valid;
    logic [1:0]                            r_redir_cause;
    logic [PC_BITS-1:0]                    r_redir_pc;
    logic [CNT_BITS-1:0]                   r_stall_cnt;

    logic [DECODE_WIDTH-1:0]               w_iv;
    logic [DECODE_WIDTH-1:0]               w_vb;
    logic [DECODE_WIDTH-1:0]               w_ij;
    logic [DECODE_WIDTH-1:0]               w_ir;
    logic [DECODE_WIDTH-1:0][DEC_BITS-1:0] w_dec;
    logic [DECODE_WIDTH-1:0][DEC_BITS-1:0] w_dec_kept;
    logic [DECODE_WIDTH-1:0]               w_keep;
    logic                                  w_any_ev;
    logic [1:0]                            w_cause;
    logic [PC_BITS-1:0]                    w_rpc;
    logic                                  w_prefix;
    logic                                  w_mis;
    logic                                  w_ill;
    logic                                  w_ret;
    logic                                  w_jl;
    logic                                  w_in_ready;
    logic                                  w_accept_run;

    for (genvar g = 0; g < DECODE_WIDTH; g++) begin : g_lane
        decoder_full #(
            .INSTR_BITS(INSTR_BITS),
            .PC_BITS   (PC_BITS)
        ) u_dec (
            .i_instr           (bus.in_instr_i[g*INSTR_BITS +: INSTR_BITS]),
            .i_pc              (bus.in_pc_i[g*PC_BITS +: PC_BITS]),
            .i_second_port_free(second_port_free_i),
            .o_is_valid        (w_iv[g]),
            .o_valid_branch    (w_vb[g]),
            .o_is_jumpl        (w_ij[g]),
            .o_is_return       (w_ir[g]),
            .o_dec             (w_dec[g])
        );
    end

    // Walk lanes oldest-first; the first lane with an event cuts the bundle.
    // A hole in the lane mask ends decoding just like a cut, without a redirect.
    always_comb begin
        w_keep   = '0;
        w_any_ev = 1'b0;
        w_cause  = 2'd0;
        w_rpc    = '0;
        w_prefix = 1'b1;
        w_mis    = 1'b0;
        w_ill    = 1'b0;
        w_ret    = 1'b0;
        w_jl     = 1'b0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            w_prefix = w_prefix & bus.in_lane_valid_i[k];
            if (w_prefix && !w_any_ev) begin
                w_mis = bus.in_taken_i[k] & ~w_vb[k] & w_iv[k];
                w_ill = ~w_iv[k];
                w_ret = w_ir[k] & w_iv[k];
                w_jl  = w_ij[k] & w_iv[k];
                if (w_mis || w_ill || w_ret || w_jl) begin
                    w_any_ev  = 1'b1;
                    w_keep[k] = w_ret | w_jl;
                    if (w_ill)      w_cause = 2'd1;
                    else if (w_mis) w_cause = 2'd0;
                    else if (w_ret) w_cause = 2'd3;
                    else            w_cause = 2'd2;
                    if (w_mis || w_ill) w_rpc = bus.in_pc_i[k*PC_BITS +: PC_BITS];
                    else                w_rpc = bus.in_pc_i[k*PC_BITS +: PC_BITS] + PC_BITS'(4);
                end else begin
                    w_keep[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_dec_kept = '0;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            if (w_keep[k]) w_dec_kept[k] = w_dec[k];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        if (flush_i) begin
            w_state_nxt = S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    w_in_ready = ~r_out_valid | bus.out_ready_i;
                    if (w_in_ready && bus.in_valid_i && w_any_ev) w_state_nxt = S_SQUASH;
                end
                S_SQUASH: begin
                    w_in_ready = 1'b1;
                    if (bus.redirect_ack_i) w_state_nxt = S_RUN;
                end
                default: w_state_nxt = S_RUN;
            endcase
        end
    end

    assign w_accept_run = bus.in_valid_i & w_in_ready & (r_state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid   <= 1'b0;
            r_lane_valid  <= '0;
            r_branch      <= '0;
            r_instr       <= '0;
            r_redir_valid <= 1'b0;
            r_redir_cause <= 2'd0;
            r_redir_pc    <= '0;
        end else if (flush_i) begin
            r_out_valid   <= 1'b0;
            r_lane_valid  <= '0;
            r_branch      <= '0;
            r_redir_valid <= 1'b0;
        end else begin
            r_redir_valid <= w_accept_run & w_any_ev;
            if (w_accept_run && w_any_ev) begin
                r_redir_cause <= w_cause;
                r_redir_pc    <= w_rpc;
            end
            if (w_accept_run) begin
                r_out_valid  <= |w_keep;
                r_lane_valid <= w_keep;
                r_branch     <= w_keep & w_vb;
                r_instr      <= w_dec_kept;
            end else if (r_out_valid && bus.out_ready_i) begin
                r_out_valid  <= 1'b0;
                r_lane_valid <= '0;
                r_branch     <= '0;
            end
        end
    end

    // Statistics survive a pipeline flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (r_out_valid && !bus.out_ready_i && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
        end
    end

    assign bus.in_ready_o       = w_in_ready;
    assign bus.out_valid_o      = r_out_valid;
    assign bus.out_lane_valid_o = r_lane_valid;
    assign bus.out_instr_o      = r_instr;
    assign bus.out_branch_o     = r_branch;
    assign bus.redirect_valid_o = r_redir_valid;
    assign bus.redirect_cause_o = r_redir_cause;
    assign bus.redirect_pc_o    = r_redir_pc;
    assign stat_stall_cnt_o     = r_stall_cnt;
endmodule
